// File: rtl/ge_encode_stream_if.sv
// Handshake bundle for ge_encode_stream: an (x, y) limb pair in, encoding bytes out.
interface ge_encode_stream_if #(
    parameter int LIMB_W = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [10*LIMB_W-1:0]  x;
    logic [10*LIMB_W-1:0]  y;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            out_byte;
    logic                  out_last;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, out_byte, out_last
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, out_byte, out_last
    );
endinterface

// File: rtl/ge_encode_stream.sv
// Canonicalises affine (x, y) in radix-2^25.5 limbs and streams the 32-byte
// Ed25519 compressed encoding (y little-endian, sign of x in bit 255).
module ge_encode_stream #(
    parameter int LIMB_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    ge_encode_stream_if.slave bus,
    output logic              busy
);
    localparam int AW = LIMB_W + 2;
    typedef logic signed [AW-1:0] acc_t;
    localparam acc_t C19 = acc_t'(32'sd19);
    localparam acc_t RND = acc_t'(32'sd16777216);

    // state    | meaning
    // ST_IDLE  | waiting for an (x, y) pair, in_ready high
    // ST_QCALC | k=0..10: quotient estimate q = floor(h / p) for x and y
    // ST_CARRY | k=0..9 : fold 19*q into limb 0, ripple carries up
    // ST_PACK  | concatenate canonical y limbs and sign of x
    // ST_SEND  | k=0..31: present byte k until accepted
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QCALC,
        ST_CARRY,
        ST_PACK,
        ST_SEND
    } state_t;

    state_t       state_q, state_d;
    acc_t         h_q [2][10];
    acc_t         h_d [2][10];
    acc_t         q_q [2];
    acc_t         q_d [2];
    logic [4:0]   k_q, k_d;
    logic [255:0] s_q, s_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         out_last_q, out_last_d;
    logic [7:0]   out_byte_q, out_byte_d;
    acc_t         sel_c, sum_c, car_c, low_c;

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        q_d         = q_q;
        k_d         = k_q;
        s_d         = s_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_byte_d  = out_byte_q;
        sel_c       = '0;
        sum_c       = '0;
        car_c       = '0;
        low_c       = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    for (int j = 0; j < 10; j++) begin
                        h_d[0][j] = {{2{bus.x[j*LIMB_W+LIMB_W-1]}}, bus.x[j*LIMB_W +: LIMB_W]};
                        h_d[1][j] = {{2{bus.y[j*LIMB_W+LIMB_W-1]}}, bus.y[j*LIMB_W +: LIMB_W]};
                    end
                    q_d[0]     = '0;
                    q_d[1]     = '0;
                    k_d        = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_QCALC;
                end
            end
            ST_QCALC: begin
                for (int l = 0; l < 2; l++) begin
                    if (k_q == 5'd0) begin
                        q_d[l] = (C19 * h_q[l][9] + RND) >>> 25;
                    end else begin
                        sel_c = '0;
                        for (int j = 0; j < 10; j++) begin
                            if (k_q == 5'(j + 1)) sel_c = h_q[l][j];
                        end
                        sum_c  = sel_c + q_q[l];
                        // k odd means limb k-1 is even, i.e. 26 bits wide
                        q_d[l] = k_q[0] ? (sum_c >>> 26) : (sum_c >>> 25);
                    end
                end
                if (k_q == 5'd10) begin
                    k_d     = '0;
                    state_d = ST_CARRY;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            ST_CARRY: begin
                for (int l = 0; l < 2; l++) begin
                    sel_c = '0;
                    for (int j = 0; j < 10; j++) begin
                        if (k_q == 5'(j)) sel_c = h_q[l][j];
                    end
                    sum_c = (k_q == 5'd0) ? (sel_c + C19 * q_q[l]) : sel_c;
                    car_c = k_q[0] ? (sum_c >>> 25) : (sum_c >>> 26);
                    low_c = k_q[0] ? (sum_c - (car_c <<< 25)) : (sum_c - (car_c <<< 26));
                    for (int j = 0; j < 10; j++) begin
                        if (k_q == 5'(j)) h_d[l][j] = low_c;
                    end
                    // carry out of limb 9 is dropped (reduction mod 2^255)
                    for (int j = 1; j < 10; j++) begin
                        if (k_q == 5'(j - 1)) h_d[l][j] = h_q[l][j] + car_c;
                    end
                end
                if (k_q == 5'd9) begin
                    k_d     = '0;
                    state_d = ST_PACK;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            ST_PACK: begin
                s_d = {h_q[0][0][0],
                       h_q[1][9][24:0], h_q[1][8][25:0], h_q[1][7][24:0], h_q[1][6][25:0],
                       h_q[1][5][24:0], h_q[1][4][25:0], h_q[1][3][24:0], h_q[1][2][25:0],
                       h_q[1][1][24:0], h_q[1][0][25:0]};
                out_byte_d  = s_d[7:0];
                out_valid_d = 1'b1;
                out_last_d  = 1'b0;
                k_d         = '0;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (bus.out_ready) begin
                    if (k_q == 5'd31) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_byte_d  = '0;
                        s_d         = '0;
                        k_d         = '0;
                        in_ready_d  = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        s_d        = s_q >> 8;
                        out_byte_d = s_q[15:8];
                        out_last_d = (k_q == 5'd30);
                        k_d        = k_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            for (int l = 0; l < 2; l++) begin
                q_q[l] <= '0;
                for (int j = 0; j < 10; j++) h_q[l][j] <= '0;
            end
            k_q         <= '0;
            s_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_byte_q  <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            q_q         <= q_d;
            k_q         <= k_d;
            s_q         <= s_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_byte_q  <= out_byte_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_byte  = out_byte_q;
    assign busy          = (state_q != ST_IDLE);
endmodule
